data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter.sv | 132 +++++++++++++
 tb/tb_data_memory_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access takes IDLE -> ACCESS -> DONE; out-of-range addresses are flagged, never written.
module data_memory_arbiter #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            prio_q;
    logic            id_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   wdata_q;

    logic            any_req_c;
    logic            win_c;
    logic            sel_we_c;
    logic [AW-1:0]   sel_addr_c;
    logic [AW-1:0]   sel_wdata_c;
    logic            sel_in_range_c;
    logic            in_range_c;

    // Winner selection and next-state logic; prio_q names the port that wins a tie.
    always_comb begin
        state_d        = state_q;
        any_req_c      = m0_req | m1_req;
        win_c          = (m0_req & m1_req) ? prio_q : m1_req;
        sel_we_c       = win_c ? m1_we    : m0_we;
        sel_addr_c     = win_c ? m1_addr  : m0_addr;
        sel_wdata_c    = win_c ? m1_wdata : m0_wdata;
        sel_in_range_c = sel_addr_c < DEPTH_W;
        in_range_c     = addr_q < DEPTH_W;
        case (state_q)
            IDLE:    if (any_req_c) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request latch, memory strobes and per-port responses; the memory bus is only live in ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_a    <= '0;
            mem_wd   <= '0;
            mem_we   <= 1'b0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            mem_a  <= '0;
            mem_wd <= '0;
            mem_we <= 1'b0;
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_c) begin
                        id_q    <= win_c;
                        we_q    <= sel_we_c;
                        addr_q  <= sel_addr_c;
                        wdata_q <= sel_wdata_c;
                        prio_q  <= ~win_c;
                        mem_a   <= sel_addr_c;
                        mem_wd  <= sel_wdata_c;
                        mem_we  <= sel_we_c & sel_in_range_c;
                    end
                end
                ACCESS: begin
                    if (id_q) begin
                        m1_ack <= 1'b1;
                        m1_err <= ~in_range_c;
                        if (!in_range_c)  m1_rdata <= '0;
                        else if (!we_q)   m1_rdata <= mem_rd;
                    end else begin
                        m0_ack <= 1'b1;
                        m0_err <= ~in_range_c;
                        if (!in_range_c)  m0_rdata <= '0;
                        else if (!we_q)   m0_rdata <= mem_rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: predictions are queued when a request is
// driven and popped by a monitor whenever an ack appears.
module tb_data_memory_arbiter;

    localparam int unsigned DEPTH = 64;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    always #5 clk = ~clk;

    data_memory_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    // Attached memory: synchronous write, combinational read.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (mem_we && mem_a < 32'(DEPTH)) mem[mem_a[5:0]] <= mem_wd;
    assign mem_rd = (mem_a < 32'(DEPTH)) ? mem[mem_a[5:0]] : 32'h0;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rd [2];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          ack_cyc[$];
    logic [31:0] we_addr_last, we_data_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                we_cnt++;
                we_addr_last = mem_a;
                we_data_last = mem_wd;
            end
            if (m0_ack || m1_ack) begin
                ack_cyc.push_back(cyc);
                check("ack_exclusive", 32'(m0_ack & m1_ack), 32'h0);
                if (sb.size() == 0) begin
                    check("ack_expected", 32'(sb.size()), 32'h1);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_port", 32'(m1_ack), 32'(mon_e.port));
                    if (mon_e.port) begin
                        check("m1_err", 32'(m1_err), 32'(mon_e.err));
                        check("m1_rdata", m1_rdata, mon_e.rdata);
                        check("m0_err_quiet", 32'(m0_err), 32'h0);
                    end else begin
                        check("m0_err", 32'(m0_err), 32'(mon_e.err));
                        check("m0_rdata", m0_rdata, mon_e.rdata);
                        check("m1_err_quiet", 32'(m1_err), 32'h0);
                    end
                end
            end
        end
    end

    function automatic exp_t predict(input logic port, input logic we,
                                     input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.port = port;
        if (addr >= 32'(DEPTH)) begin
            e.err = 1'b1;
            exp_rd[port] = 32'h0;
        end else begin
            e.err = 1'b0;
            if (we) ref_mem[addr[5:0]] = wdata;
            else    exp_rd[port] = ref_mem[addr[5:0]];
        end
        e.rdata = exp_rd[port];
        return e;
    endfunction

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // Called just after a rising edge with the arbiter idle; returns just after a rising edge.
    task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int  w0;
        int  lat;
        bit  seen;
        bit  in_rng;
        in_rng = addr < 32'(DEPTH);
        sb.push_back(predict(port, we, addr, wdata));
        w0 = we_cnt;
        drive(port, 1'b1, we, addr, wdata);
        lat = 0;
        seen = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            if (port ? m1_ack : m0_ack) seen = 1;
            else lat++;
        end
        check("ack_latency", 32'(lat), 32'd2);
        @(posedge clk);
        #1;
        drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
        check("we_pulses", 32'(we_cnt - w0), (we && in_rng) ? 32'd1 : 32'd0);
        if (we && in_rng) begin
            check("we_addr", we_addr_last, addr);
            check("we_data", we_data_last, wdata);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Both ports hold read requests; only valid straight after reset, so grants run 0,1,0,1...
    task automatic run_both(input logic [31:0] a0, input logic [31:0] a1, input int n);
        int got;
        int cycles;
        int base;
        for (int i = 0; i < n; i++) sb.push_back(predict(1'(i % 2), 1'b0, (i % 2) ? a1 : a0, 32'h0));
        base = ack_cyc.size();
        drive(1'b0, 1'b1, 1'b0, a0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, a1, 32'h0);
        got = 0;
        cycles = 0;
        while (got < n && cycles < 6 * n) begin
            @(negedge clk);
            cycles++;
            if (m0_ack || m1_ack) got++;
        end
        check("contention_acks", 32'(got), 32'(n));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = base + 1; i < ack_cyc.size(); i++)
            check("ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        #12;
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        check("mem_word5", mem[5], 32'hDEADBEEF);
        issue(1'b1, 1'b0, 32'd5, 32'h0);
        @(negedge clk);
        check("m1_rdata_hold", m1_rdata, 32'hDEADBEEF);
        check("m1_ack_fell", 32'(m1_ack), 32'h0);
        @(posedge clk);
        #1;

        issue(1'b1, 1'b1, 32'd63, 32'hCAFEF00D);
        issue(1'b0, 1'b0, 32'd63, 32'h0);
        issue(1'b0, 1'b1, 32'd7, 32'h0BADC0DE);
        issue(1'b0, 1'b1, 32'd64, 32'h55555555);
        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        issue(1'b1, 1'b0, 32'd7, 32'h0);

        do_reset();
        run_both(32'd5, 32'd63, 4);

        issue(1'b1, 1'b1, 32'd3, 32'hAAAA5555);
        drive(1'b0, 1'b1, 1'b1, 32'd3, 32'h1234);
        @(posedge clk);
        #2;
        check("abort_we_live", 32'(mem_we), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_we_drop", 32'(mem_we), 32'h0);
        check("abort_a_drop", mem_a, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_word3", mem[3], 32'hAAAA5555);
        check("abort_m1_rdata", m1_rdata, 32'h0);
        run_both(32'd3, 32'd5, 2);
        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
